afifo_rd_side: RTL
==================

// Module: afifo_rd_side
// PURPOSE
//  Read-domain controller of the async FIFO, the consumer end of the dual-port RAM.
//  Synchronises the write-domain Gray pointer into rclk and maintains the read pointer.
//  Generates empty, almost-empty and level.
//  Presents data through a registered show-ahead valid/ready output stage.
// PARAMETERS
//  DSIZE     8  data width (matches RAM word)
//  ASIZE     3  RAM address width; depth = 2**ASIZE
//  AE_THRESH 1  o_almost_empty asserts when rd_level <= AE_THRESH
// PORTS
//  rclk            in   1        read clock (single clock)
//  rrst_n          in   1        async active-low reset
//  wptr_gray       in   ASIZE+1  write pointer, Gray, from wclk domain (async)
//  rptr_gray       out  ASIZE+1  read pointer, Gray, registered; to write-side sync
//  rd_addr         out  ASIZE    RAM read address = rbin[ASIZE-1:0]
//  rd_en           out  1        pop strobe to RAM (combinational, = pop)
//  rd_data         in   DSIZE    RAM async-read data at rd_addr
//  m_data          out  DSIZE    output data, registered
//  m_valid         out  1        m_data valid
//  m_ready         in   1        consumer accepts m_data when m_valid & m_ready
//  o_rempty        out  1        RAM holds no unread word (registered)
//  o_almost_empty  out  1        registered
//  rd_level        out  ASIZE+1  synced word count in RAM, excludes output reg
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - wq1 = wq2 = rbin = rptr_gray = 0; m_data = 0; m_valid = 0.
//   - o_rempty = 1; o_almost_empty = 1; rd_level = 0.
//  Sync: wq1 <= wptr_gray; wq2 <= wq1 (2 flops; no logic between them).
//   - wq2_bin = gray2bin(wq2).
//  pop = !o_rempty & (!m_valid | m_ready). rd_en = pop.
//  On pop:
//   - m_data <= rd_data; m_valid <= 1.
//   - rbin <= rbin+1, wrapping mod 2**(ASIZE+1).
//  m_valid & m_ready & !pop: m_valid <= 0; m_data holds.
//  m_valid & !m_ready: m_data and m_valid hold (no overwrite, no pop).
//  rbin_next = rbin + pop; rptr_gray <= bin2gray(rbin_next).
//  o_rempty <= (bin2gray(rbin_next) == wq2).
//  rd_level = wq2_bin - rbin, ASIZE+1-bit modular subtraction; registered.
//   - Max value 2**ASIZE.
//  o_almost_empty registered from (wq2_bin - rbin_next) <= AE_THRESH.
//  Latency: wptr_gray change stable before edge 1 -> wq2 updated at edge 2.
//   - o_rempty falls at edge 3; m_valid rises at edge 4.
//  Throughput: one word per rclk while non-empty and m_ready = 1.
//  Wrap: pointer MSB distinguishes laps; address wraps 2**ASIZE-1 -> 0 without bubble.
//  Simultaneous accept and pop: both happen in the same cycle; m_valid stays 1.
//  Reset mid-stream: buffered m_data is discarded and m_valid drops immediately.
//   - Write side must be reset together with this block.
//  Never pops when o_rempty = 1; stale (late) wq2 only delays non-empty, never false data.
// STRUCTURE
//  Shared include afifo_pkg:
//   - bin2gray / gray2bin functions.
//   - DSIZE / ASIZE defaults shared with the write side and the RAM.
//  Sub-module afifo_sync2: parameterised 2-flop synchroniser with async active-low reset.
//   - Write side reuses it for rptr_gray.
//  Rest is flat:
//   - pointer/flag register block.
//   - output stage register block.
// TESTING
//  1. Reset with wptr_gray = 0 -> o_rempty = 1, m_valid = 0, rd_level = 0, rptr_gray = 0.
//  2. wptr_gray 0 -> 1 (bin 1), m_ready = 1, RAM[0] = 8'hA5:
//     - o_rempty falls at edge 3.
//     - m_valid = 1 with m_data = A5 at edge 4.
//     - rptr_gray = 1 and o_rempty = 1 after the pop.
//  3. Write 8 words (wptr bin 8, Gray 4'b1100), m_ready = 0:
//     - exactly one pop into the output reg; rd_level = 7.
//     - m_data stable while stalled.
//  4. Test 3 continued, raise m_ready:
//     - 8 words delivered on consecutive cycles, in address order 0..7.
//     - rd_addr wraps 7 -> 0; rbin = 8, rptr_gray = 4'b1100.
//  5. Level 3, AE_THRESH = 1:
//     - o_almost_empty asserts when level reaches 1; o_rempty asserts at 0.
//     - no rd_en while empty.
//  6. Assert rrst_n low while m_valid = 1 and level = 4:
//     - all outputs return to reset values asynchronously, before the next rclk.

Source files
------------

// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
// Shared definitions for both halves of the asynchronous FIFO (write side,
// read side and the dual-port RAM between them).
//
// Contents
//   DSIZE_DEF / ASIZE_DEF : default data width and RAM address width, so the
//                           write side, read side and RAM agree unless a
//                           parent overrides all three together.
//   bin2gray / gray2bin   : pointer encoding helpers. They work on a 32-bit
//                           container; callers zero-extend their ASIZE+1 bit
//                           pointer in and keep the low ASIZE+1 bits out.
//                           Zero upper bits are transparent to both
//                           conversions, so any pointer width up to 32 bits
//                           works.
// -----------------------------------------------------------------------------
package afifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 3;

    // Binary to reflected Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: each binary bit is the XOR of all
    // Gray bits at and above its position.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : afifo_pkg

// File: rtl/afifo_sync2.sv
// -----------------------------------------------------------------------------
// afifo_sync2
// Two-flop synchroniser for a multi-bit Gray-coded pointer crossing into the
// i_clk domain. Only one bit of a Gray pointer changes per step, so each bit
// may be sampled independently; a bit caught mid-transition resolves to
// either the old or the new pointer value, both of which are safe.
//
// There is deliberately no logic between the two flops: the first stage is
// allowed to go metastable and gets a full cycle to settle.
//
// Used by the read side (write pointer into rclk) and by the write side
// (read pointer into wclk).
//
// Ports
//   i_clk    in   1      destination clock
//   i_rst_n  in   1      async active-low reset, clears both stages
//   i_d      in   WIDTH  asynchronous input (Gray pointer)
//   o_q      out  WIDTH  synchronised output (second stage)
// -----------------------------------------------------------------------------
module afifo_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule : afifo_sync2

// File: rtl/afifo_rd_side.sv
// -----------------------------------------------------------------------------
// afifo_rd_side
// Read-domain controller of the asynchronous FIFO: the consumer end of the
// dual-port RAM. It brings the write pointer into rclk, keeps the read
// pointer, derives empty / almost-empty / level, and presents data through a
// registered show-ahead valid/ready stage (one word buffered outside the RAM).
//
// Parameters
//   DSIZE      data width (RAM word)
//   ASIZE      RAM address width, depth = 2**ASIZE
//   AE_THRESH  o_almost_empty asserts when the RAM word count <= AE_THRESH
//
// Ports
//   rclk            in   1        read clock
//   rrst_n          in   1        async active-low reset (sync release upstream)
//   wptr_gray       in   ASIZE+1  write pointer, Gray, from the wclk domain
//   rptr_gray       out  ASIZE+1  read pointer, Gray, registered
//   rd_addr         out  ASIZE    RAM read address
//   rd_en           out  1        pop strobe to the RAM (combinational)
//   rd_data         in   DSIZE    RAM async-read data at rd_addr
//   m_data          out  DSIZE    output data, registered
//   m_valid         out  1        m_data valid
//   m_ready         in   1        consumer accept
//   o_rempty        out  1        RAM holds no unread word, registered
//   o_almost_empty  out  1        registered
//   rd_level        out  ASIZE+1  synced RAM word count (excludes m_data)
//
// Pointers are ASIZE+1 bits wide: the extra MSB counts laps so a full RAM
// (difference 2**ASIZE) is distinguishable from an empty one (difference 0).
// -----------------------------------------------------------------------------
module afifo_rd_side
    import afifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ASIZE     = ASIZE_DEF,
    parameter int AE_THRESH = 1
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr_gray,
    output logic [ASIZE:0]   rptr_gray,
    output logic [ASIZE-1:0] rd_addr,
    output logic             rd_en,
    input  logic [DSIZE-1:0] rd_data,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             o_rempty,
    output logic             o_almost_empty,
    output logic [ASIZE:0]   rd_level
);

    localparam int PW = ASIZE + 1;

    // ---------------------------------------------------------------------
    // Write pointer into rclk
    // ---------------------------------------------------------------------
    logic [PW-1:0] w_wq2;
    logic [31:0]   w_wq2_bin32;
    logic [PW-1:0] w_wq2_bin;

    afifo_sync2 #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .i_clk   (rclk),
        .i_rst_n (rrst_n),
        .i_d     (wptr_gray),
        .o_q     (w_wq2)
    );

    assign w_wq2_bin32 = gray2bin(32'(w_wq2));
    assign w_wq2_bin   = w_wq2_bin32[PW-1:0];

    // ---------------------------------------------------------------------
    // Pop decision
    // A word leaves the RAM whenever there is one and the output register is
    // free or being drained this same cycle. o_rempty is registered against
    // the synchronised (possibly stale) write pointer, so a late wq2 can only
    // hold off a pop, never cause a read of an unwritten word.
    // ---------------------------------------------------------------------
    logic          w_pop;
    logic [PW-1:0] r_rbin;
    logic [PW-1:0] w_rbin_next;
    logic [31:0]   w_rgray_next32;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_ae_level;

    assign w_pop          = !o_rempty && (!m_valid || m_ready);
    assign rd_en          = w_pop;
    assign rd_addr        = r_rbin[ASIZE-1:0];

    // Modular increment: the MSB toggles each lap while the address bits
    // wrap 2**ASIZE-1 -> 0 with no bubble.
    assign w_rbin_next    = r_rbin + {{(PW-1){1'b0}}, w_pop};
    assign w_rgray_next32 = bin2gray(32'(w_rbin_next));
    assign w_rgray_next   = w_rgray_next32[PW-1:0];

    // Look-ahead count so almost-empty reflects this cycle's pop.
    assign w_ae_level     = w_wq2_bin - w_rbin_next;

    // Upper container bits of the conversion helpers are always zero.
    logic w_unused_hi;
    assign w_unused_hi = ^{w_wq2_bin32[31:PW], w_rgray_next32[31:PW]};

    // ---------------------------------------------------------------------
    // Pointer / flag registers
    // ---------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin         <= '0;
            rptr_gray      <= '0;
            o_rempty       <= 1'b1;
            o_almost_empty <= 1'b1;
            rd_level       <= '0;
        end else begin
            r_rbin         <= w_rbin_next;
            rptr_gray      <= w_rgray_next;
            o_rempty       <= (w_rgray_next == w_wq2);
            o_almost_empty <= (w_ae_level <= PW'(AE_THRESH));
            // Modular difference; with the lap bit this spans 0..2**ASIZE.
            rd_level       <= w_wq2_bin - r_rbin;
        end
    end

    // ---------------------------------------------------------------------
    // Output stage
    // Pop overrides accept: a simultaneous accept and pop reloads m_data and
    // keeps m_valid high, giving one word per cycle. When stalled (valid and
    // not ready) there is no pop, so m_data is never overwritten.
    // ---------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (w_pop) begin
            m_data  <= rd_data;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule : afifo_rd_side
